// File: rtl/matrix_fetch_responder.sv
// -----------------------------------------------------------------------------
// matrix_fetch_responder
//
// Memory-side responder for the weight port of the matrix-vector multiplier.
// A MAX_ROWS*MAX_COLS word weight store is filled one word at a time through
// the host load port.  The multiplier asks for a chunk with matrix_enable and
// matrix_addr.  The responder then reads BANDWIDTH consecutive words, one per
// cycle, and packs them into matrix_data.  When the chunk is complete it
// raises matrix_ready.
//
// Request/ready handshake:
//   The multiplier raises matrix_enable with the chunk start in matrix_addr.
//   The first rising edge that sees enable high (E0) latches the address.
//   matrix_addr is not looked at again until the next request.
//   matrix_ready goes high once every slot of the chunk has been written.
//   It stays high for as long as enable is held.
//   The first edge with enable low returns the block to IDLE and clears
//   matrix_ready.  matrix_data then holds the chunk until the next request
//   starts, so the multiplier consumes it after dropping enable.
//   Dropping enable before matrix_ready rises abandons the fetch.
//   A new request needs enable low for at least one edge.
//
// Ports:
//   clk           in   clock
//   rst_n         in   synchronous active-low reset (store is not reset)
//   wr_en         in   host weight write strobe (stalls an active fetch)
//   wr_addr       in   host write address, ignored when >= DEPTH
//   wr_data       in   host write word
//   matrix_enable in   fetch request / hold
//   matrix_addr   in   word address of the first word in the chunk
//   matrix_data   out  packed chunk, word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   matrix_ready  out  chunk complete and valid
//   busy          out  responder is not idle
//   oor_flag      out  last chunk touched addresses >= DEPTH
// -----------------------------------------------------------------------------
module matrix_fetch_responder #(
   parameter int MAX_ROWS   = 64,
   parameter int MAX_COLS   = 64,
   parameter int BANDWIDTH  = 16,
   parameter int DATA_WIDTH = 16,
   localparam int DEPTH     = MAX_ROWS * MAX_COLS,
   localparam int ADDR_W    = $clog2(DEPTH)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            wr_en,
   input  logic [ADDR_W-1:0]               wr_addr,
   input  logic [DATA_WIDTH-1:0]           wr_data,
   input  logic                            matrix_enable,
   input  logic [ADDR_W-1:0]               matrix_addr,
   output logic [DATA_WIDTH*BANDWIDTH-1:0] matrix_data,
   output logic                            matrix_ready,
   output logic                            busy,
   output logic                            oor_flag
);

   // Slot counter width.  It must hold values up to BANDWIDTH-1.
   localparam int CNT_W = (BANDWIDTH > 1) ? $clog2(BANDWIDTH) : 1;

   localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(BANDWIDTH - 1);
   // DEPTH compared at ADDR_W+1 bits, so base+cnt past the end of the
   // store is seen as out of range instead of wrapping back to zero.
   localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      READY = 2'd2
   } state_t;

   state_t                  state;
   logic [CNT_W-1:0]        cnt;
   logic [ADDR_W-1:0]       base;

   // Weight store: a single write port and an asynchronous read port.
   // The store is not reset.
   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   logic [ADDR_W:0]         rd_addr_ext;
   logic                    rd_oor;
   logic [DATA_WIDTH-1:0]   rd_word;
   logic                    wr_ok;
   logic                    last_slot;

   // -------------------------------------------------------------------------
   // Read address and range check
   // -------------------------------------------------------------------------
   always_comb begin
      rd_addr_ext = '0;
      rd_oor      = 1'b0;
      rd_word     = '0;
      wr_ok       = 1'b0;
      last_slot   = 1'b0;

      rd_addr_ext = {1'b0, base} + {{(ADDR_W + 1 - CNT_W){1'b0}}, cnt};
      rd_oor      = (rd_addr_ext >= DEPTH_EXT);
      // Out-of-range slots are filled with zero rather than aliased data.
      rd_word     = rd_oor ? '0 : mem[rd_addr_ext[ADDR_W-1:0]];
      wr_ok       = ({1'b0, wr_addr} < DEPTH_EXT);
      last_slot   = (cnt == LAST_CNT);
   end

   // -------------------------------------------------------------------------
   // Host write port.  It is active in every state.  A write during FETCH
   // takes the single store port, so the FSM stalls that cycle.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (wr_en && wr_ok) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // -------------------------------------------------------------------------
   // Fetch FSM.  Every output is a register.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         base         <= '0;
         matrix_data  <= '0;
         matrix_ready <= 1'b0;
         busy         <= 1'b0;
         oor_flag     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (matrix_enable) begin
                  state       <= FETCH;
                  base        <= matrix_addr;
                  cnt         <= '0;
                  oor_flag    <= 1'b0;
                  matrix_data <= '0;
                  busy        <= 1'b1;
               end
            end

            FETCH: begin
               if (!matrix_enable) begin
                  // Abort.  The partial chunk and the partial oor_flag are
                  // kept.  matrix_ready was never raised.
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (!wr_en) begin
                  matrix_data[cnt*DATA_WIDTH +: DATA_WIDTH] <= rd_word;
                  if (rd_oor) begin
                     oor_flag <= 1'b1;
                  end
                  if (last_slot) begin
                     state        <= READY;
                     matrix_ready <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               // When wr_en is high this is a stall cycle: nothing is read
               // and cnt holds.
            end

            READY: begin
               // Holding enable high keeps the block in READY.  A refetch
               // needs enable low for at least one edge.
               if (!matrix_enable) begin
                  state        <= IDLE;
                  matrix_ready <= 1'b0;
                  busy         <= 1'b0;
               end
            end

            default: begin
               state        <= IDLE;
               matrix_ready <= 1'b0;
               busy         <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_fetch_responder.sv
// -----------------------------------------------------------------------------
// tb_matrix_fetch_responder
//
// Directed bench for matrix_fetch_responder with the default parameters:
// 64x64 store, 16 words of 16 bits per fetch.  The store is preloaded with
// mem[i] = i.  Then fetches, aborts, stalls, out-of-range chunks and a
// reset during a fetch are run, and the results are checked against values
// worked out by hand.
// -----------------------------------------------------------------------------
module tb_matrix_fetch_responder;

   localparam int BW     = 16;
   localparam int DW     = 16;
   localparam int DEPTH  = 4096;
   localparam int ADDR_W = 12;

   logic                clk;
   logic                rst_n;
   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic [DW-1:0]       wr_data;
   logic                matrix_enable;
   logic [ADDR_W-1:0]   matrix_addr;
   logic [DW*BW-1:0]    matrix_data;
   logic                matrix_ready;
   logic                busy;
   logic                oor_flag;

   int n_checks = 0;
   int n_fail   = 0;

   matrix_fetch_responder dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .matrix_enable (matrix_enable),
      .matrix_addr   (matrix_addr),
      .matrix_data   (matrix_data),
      .matrix_ready  (matrix_ready),
      .busy          (busy),
      .oor_flag      (oor_flag)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge.  Inputs are driven and outputs sampled 1 ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Word k is expected to be start+k for k < n_valid and 0 otherwise.
   // If patch_idx >= 0, word patch_idx is expected to be patch_val instead.
   task automatic check_words(input string tag, input int start, input int n_valid,
                              input int patch_idx, input logic [DW-1:0] patch_val);
      logic [DW-1:0] exp_w;
      for (int k = 0; k < BW; k++) begin
         exp_w = (k < n_valid) ? DW'(start + k) : '0;
         if (k == patch_idx) exp_w = patch_val;
         check($sformatf("%s word%0d", tag, k), 32'(matrix_data[k*DW +: DW]), 32'(exp_w));
      end
   endtask

   // Ticks until matrix_ready rises, giving up after 64 edges.
   task automatic wait_ready(output int edges);
      edges = 0;
      while (!matrix_ready && edges < 64) begin
         tick();
         edges++;
      end
   endtask

   initial begin : stim
      int edges;

      rst_n         = 1'b0;
      wr_en         = 1'b0;
      wr_addr       = '0;
      wr_data       = '0;
      matrix_enable = 1'b0;
      matrix_addr   = '0;

      // ---------------- reset ----------------
      tick();
      tick();
      check("rst ready", 32'(matrix_ready), 0);
      check("rst busy",  32'(busy), 0);
      check("rst oor",   32'(oor_flag), 0);
      check("rst data0", 32'(matrix_data[31:0]), 0);
      rst_n = 1'b1;
      tick();
      check("post rst busy", 32'(busy), 0);

      // ---------------- preload mem[i] = i ----------------
      for (int i = 0; i < DEPTH; i++) begin
         wr_en   = 1'b1;
         wr_addr = ADDR_W'(i);
         wr_data = DW'(i);
         tick();
      end
      wr_en = 1'b0;
      tick();

      // ---------------- fetch at 32, check latency ----------------
      matrix_addr   = 12'd32;
      matrix_enable = 1'b1;
      tick();                              // E0
      matrix_addr   = 12'd500;             // must be ignored
      check("t1 E0 busy",  32'(busy), 1);
      check("t1 E0 ready", 32'(matrix_ready), 0);
      for (int e = 1; e < BW; e++) begin
         tick();
         check($sformatf("t1 E%0d ready", e), 32'(matrix_ready), 0);
         check($sformatf("t1 E%0d busy", e),  32'(busy), 1);
      end
      tick();                              // E16
      check("t1 ready", 32'(matrix_ready), 1);
      check("t1 busy",  32'(busy), 1);
      check("t1 oor",   32'(oor_flag), 0);
      check_words("t1", 32, BW, -1, '0);
      // Enable held high: stay READY and do not refetch.
      tick();
      tick();
      check("t1 hold ready", 32'(matrix_ready), 1);
      check_words("t1 hold", 32, BW, -1, '0);

      // ---------------- drop enable, data hold ----------------
      matrix_enable = 1'b0;
      tick();
      check("t2 ready", 32'(matrix_ready), 0);
      check("t2 busy",  32'(busy), 0);
      for (int i = 0; i < 10; i++) begin
         tick();
         check($sformatf("t2 idle%0d word0", i),  32'(matrix_data[15:0]), 32);
         check($sformatf("t2 idle%0d word15", i), 32'(matrix_data[255:240]), 47);
      end
      check_words("t2", 32, BW, -1, '0);

      // ---------------- out of range at 4090 ----------------
      matrix_addr   = 12'd4090;
      matrix_enable = 1'b1;
      tick();
      wait_ready(edges);
      check("t3 latency", 32'(edges), BW);
      check("t3 oor", 32'(oor_flag), 1);
      check_words("t3", 4090, 6, -1, '0);
      matrix_enable = 1'b0;
      tick();
      check("t3 oor after idle", 32'(oor_flag), 1);
      matrix_addr   = 12'd0;
      matrix_enable = 1'b1;
      tick();                              // E0 clears oor_flag and the data
      check("t3b E0 oor",   32'(oor_flag), 0);
      check("t3b E0 data0", 32'(matrix_data[15:0]), 0);
      wait_ready(edges);
      check("t3b latency", 32'(edges), BW);
      check("t3b oor", 32'(oor_flag), 0);
      check_words("t3b", 0, BW, -1, '0);
      matrix_enable = 1'b0;
      tick();

      // ---------------- 2-cycle write stall mid-fetch ----------------
      matrix_addr   = 12'd0;
      matrix_enable = 1'b1;
      tick();                              // E0
      for (int i = 0; i < 5; i++) tick();  // slots 0..4
      wr_en   = 1'b1;
      wr_addr = 12'd10;
      wr_data = 16'hBEEF;
      tick();
      tick();                              // two stall cycles
      wr_en   = 1'b0;
      check("t4 stall ready", 32'(matrix_ready), 0);
      wait_ready(edges);
      check("t4 latency", 32'(7 + edges), BW + 2);
      check_words("t4", 0, BW, 10, 16'hBEEF);
      matrix_enable = 1'b0;
      tick();

      // ---------------- abort after 5 fetch cycles ----------------
      matrix_addr   = 12'd16;
      matrix_enable = 1'b1;
      tick();                              // E0
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("t5 fetch%0d ready", i), 32'(matrix_ready), 0);
      end
      matrix_enable = 1'b0;
      tick();
      check("t5 abort busy",  32'(busy), 0);
      check("t5 abort ready", 32'(matrix_ready), 0);
      tick();
      check("t5 idle ready", 32'(matrix_ready), 0);
      check_words("t5 partial", 16, 5, -1, '0);

      // New request at 64.  A write to mem[70] lands on the same IDLE edge.
      matrix_addr   = 12'd64;
      matrix_enable = 1'b1;
      wr_en         = 1'b1;
      wr_addr       = 12'd70;
      wr_data       = 16'h1234;
      tick();                              // E0, write completes here
      wr_en = 1'b0;
      wait_ready(edges);
      check("t5b latency", 32'(edges), BW);
      check_words("t5b", 64, BW, 6, 16'h1234);
      matrix_enable = 1'b0;
      tick();

      // ---------------- reset mid-fetch ----------------
      matrix_addr   = 12'd32;
      matrix_enable = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) tick();
      rst_n         = 1'b0;
      matrix_enable = 1'b0;
      tick();
      check("t6 rst ready", 32'(matrix_ready), 0);
      check("t6 rst busy",  32'(busy), 0);
      check("t6 rst oor",   32'(oor_flag), 0);
      check_words("t6 rst", 0, 0, -1, '0);
      rst_n = 1'b1;
      tick();
      matrix_addr   = 12'd32;
      matrix_enable = 1'b1;
      tick();
      wait_ready(edges);
      check("t6 refetch latency", 32'(edges), BW);
      check_words("t6 refetch", 32, BW, -1, '0);
      matrix_enable = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

endmodule
